// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states, latched request.
// Build option MEM_MISALIGN_TRAP_EN (see mem_lsu.sv) selects whether misaligned accesses trap.
package mem_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // True when an access cannot be served with the trap option enabled.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lo[0];
      SIZE_WORD: bad = (lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bundle of core request/response and memory port signals around the load/store unit.
// slave = the LSU's view; master = the core plus memory environment view.
interface mem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );

endinterface

// File: rtl/mem_lane.sv
// Combinational lane logic: extract/extend a sub-word for loads and merge store data
// into a read word for sub-word stores. Reserved size is treated as a full word.
module mem_lane
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [1:0]  lane_eff;
  logic [31:0] shifted;
  logic [31:0] wdata_rep;
  logic [3:0]  byte_en;

  always_comb begin
    lane_eff  = 2'b00;
    wdata_rep = wdata;
    byte_en   = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        lane_eff  = lane;
        wdata_rep = {4{wdata[7:0]}};
        byte_en   = 4'b0001 << lane;
      end
      SIZE_HALF: begin
        lane_eff  = {lane[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_eff  = 2'b00;
        wdata_rep = wdata;
        byte_en   = 4'b1111;
      end
    endcase
  end

  assign shifted = word >> {lane_eff, 3'b000};

  always_comb begin
    case (size)
      SIZE_BYTE: load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

  // Replicated store data already sits in every lane; byte enables pick which ones land.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit FSM: one request at a time, sub-word stores via read-modify-write.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned/reserved accesses with rsp_err.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  mem_lsu_if.slave bus
);

  state_t      state_reg;
  state_t      state_next;
  req_t        req_reg;
  logic [31:0] rdata_reg;
  logic [31:0] merge_reg;
  logic        accept;
  logic        req_err;
  logic [31:0] word_addr;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign accept    = (state_reg == IDLE) && bus.req_valid;
  assign word_addr = {req_reg.addr[31:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_reg;

  assign req_err     = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign bus.rsp_err = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= req_err;
    end
  end
`else
  assign req_err     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  mem_lane u_lane (
    .size      (req_reg.size),
    .sgn       (req_reg.sgn),
    .lane      (req_reg.addr[1:0]),
    .word      (bus.mem_rd),
    .wdata     (req_reg.wdata),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Memory-side outputs depend on state only, so reset removes mem_we at once.
  always_comb begin
    state_next    = state_reg;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_a     = 32'h0;
    bus.mem_wd    = 32'h0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)             state_next = RESP;
          else if (!bus.req_we)    state_next = LOAD;
          else if (bus.req_size[1]) state_next = WRITE;
          else                     state_next = MERGE;
        end
      end
      LOAD: begin
        bus.mem_a  = word_addr;
        state_next = RESP;
      end
      MERGE: begin
        bus.mem_a  = word_addr;
        state_next = WRITE;
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        bus.mem_a  = word_addr;
        bus.mem_wd = req_reg.size[1] ? req_reg.wdata : merge_reg;
        state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_reg   <= '0;
      rdata_reg <= 32'h0;
      merge_reg <= 32'h0;
    end else begin
      if (accept) begin
        req_reg   <= '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                       addr: bus.req_addr, wdata: bus.req_wdata};
        rdata_reg <= 32'h0;
      end
      if (state_reg == LOAD) begin
        rdata_reg <= lane_load;
      end
      if (state_reg == MERGE) begin
        merge_reg <= lane_merged;
      end
    end
  end

  assign bus.rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: byte-level reference model, per-cycle compare process,
// and literal checks taken from hand-worked memory/load values.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  assign bus.mem_rd = mem[bus.mem_a[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  bit          busy = 0;
  bit          chk_on = 0;
  int          acc;
  int          exp_lat;
  int          exp_wk;
  bit          exp_err;
  logic [31:0] exp_rdata, exp_wd, exp_wa;
  logic [31:0] last_rdata;
  logic [31:0] last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: works on bytes of the addressed word, independent of any state machine.
  task automatic model(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [1:0]  sz;
    logic [31:0] w, v;
    int          n, base;
    bit          err;
    sz = size;
`ifdef MEM_MISALIGN_TRAP_EN
    err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
`else
    err = 0;
    if (sz == 2'd3) sz = 2'd2;
`endif
    n    = 1 << sz;
    base = (sz == 2'd2) ? 0 : (sz == 2'd1) ? (addr[1] ? 2 : 0) : int'(addr[1:0]);
    w    = ref_mem[addr[7:2]];
    exp_err   = err;
    exp_wa    = {addr[31:2], 2'b00};
    exp_rdata = 32'h0;
    exp_wd    = 32'h0;
    exp_wk    = -1;
    if (err) begin
      exp_lat = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(w[8*(base+i) +: 8]) << (8*i));
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      exp_rdata = v;
      exp_lat   = 2;
    end else begin
      for (int i = 0; i < n; i++) w[8*(base+i) +: 8] = wdata[8*i +: 8];
      ref_mem[addr[7:2]] = w;
      exp_wd  = w;
      exp_lat = (n == 4) ? 2 : 3;
      exp_wk  = exp_lat - 1;
    end
  endtask

  // Compare process: k counts cycles after the accept edge (LOAD/MERGE/WRITE start at k=1).
  always @(negedge clk) begin
    if (chk_on && reset) begin
      if (busy) begin
        automatic int k = cyc - acc + 1;
        chk("req_ready_busy", 32'(bus.req_ready), 32'(0));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(k == exp_lat));
        chk("mem_we", 32'(bus.mem_we), 32'(k == exp_wk));
        if (!exp_err && k < exp_lat) chk("mem_a", bus.mem_a, exp_wa);
        if (k == exp_wk) chk("mem_wd", bus.mem_wd, exp_wd);
        if (k >= exp_lat) begin
          chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
          chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
          chk("mem_word", mem[exp_wa[7:2]], ref_mem[exp_wa[7:2]]);
          last_rdata = bus.rsp_rdata;
          last_err   = 32'(bus.rsp_err);
          busy = 0;
        end
      end else begin
        chk("req_ready_idle", 32'(bus.req_ready), 32'(1));
        chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'(0));
        chk("mem_we_idle", 32'(bus.mem_we), 32'(0));
      end
    end
  end

  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit poke);
    @(negedge clk);
    bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    model(we, size, sgn, addr, wdata);
    acc  = cyc;
    busy = 1;
    bus.req_valid = 1'b0;
    if (poke) begin
      // A request while busy must be dropped, not queued.
      bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h80;
      bus.req_wdata = 32'hBAD0BAD0; bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (exp_lat - 1) @(posedge clk);
    end else begin
      repeat (exp_lat) @(posedge clk);
    end
    #1;
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          poke;
    int          kind;   // 0 none, 1 rdata literal, 2 memory word literal, 3 error flagged
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    last_rdata = 0; last_err = 0;
    for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end

    vecs.push_back('{1, 2'd2, 0, 32'h40, 32'h11223344, 0, 2, 32'h11223344});
    vecs.push_back('{0, 2'd2, 0, 32'h40, 32'h0,        0, 1, 32'h11223344});
    vecs.push_back('{1, 2'd0, 0, 32'h41, 32'h000000AA, 0, 2, 32'h1122AA44});
    vecs.push_back('{0, 2'd0, 1, 32'h41, 32'h0,        0, 1, 32'hFFFFFFAA});
    vecs.push_back('{0, 2'd0, 0, 32'h41, 32'h0,        0, 1, 32'h000000AA});
    vecs.push_back('{1, 2'd1, 0, 32'h42, 32'h00008001, 0, 2, 32'h8001AA44});
    vecs.push_back('{0, 2'd1, 1, 32'h42, 32'h0,        0, 1, 32'hFFFF8001});
    vecs.push_back('{0, 2'd1, 0, 32'h42, 32'h0,        0, 1, 32'h00008001});
`ifdef MEM_MISALIGN_TRAP_EN
    vecs.push_back('{1, 2'd2, 0, 32'h42, 32'hDEADBEEF, 0, 3, 32'h1});
    vecs.push_back('{0, 2'd2, 0, 32'h40, 32'h0,        0, 1, 32'h8001AA44});
    vecs.push_back('{1, 2'd0, 0, 32'h43, 32'h0000005A, 1, 2, 32'h5A01AA44});
    vecs.push_back('{0, 2'd0, 1, 32'h43, 32'h0,        0, 1, 32'h0000005A});
    vecs.push_back('{0, 2'd3, 0, 32'h40, 32'h0,        0, 3, 32'h1});
    vecs.push_back('{0, 2'd1, 1, 32'h41, 32'h0,        0, 3, 32'h1});
`else
    vecs.push_back('{1, 2'd2, 0, 32'h42, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF});
    vecs.push_back('{0, 2'd2, 0, 32'h40, 32'h0,        0, 1, 32'hDEADBEEF});
    vecs.push_back('{1, 2'd0, 0, 32'h43, 32'h0000005A, 1, 2, 32'h5AADBEEF});
    vecs.push_back('{0, 2'd0, 1, 32'h43, 32'h0,        0, 1, 32'h0000005A});
    vecs.push_back('{0, 2'd3, 0, 32'h40, 32'h0,        0, 1, 32'h5AADBEEF});
    vecs.push_back('{0, 2'd1, 1, 32'h41, 32'h0,        0, 1, 32'hFFFFBEEF});
`endif
    vecs.push_back('{1, 2'd1, 0, 32'h4E, 32'h00001234, 0, 2, 32'h12340000});
    vecs.push_back('{0, 2'd0, 1, 32'h4E, 32'h0,        0, 1, 32'h00000034});
    vecs.push_back('{1, 2'd2, 0, 32'h48, 32'hCAFEF00D, 0, 2, 32'hCAFEF00D});

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
    @(negedge clk);
    reset  = 1'b1;
    chk_on = 1;

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, vecs[i].poke);
      $display("vec %0d: we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
               i, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
               last_rdata, last_err);
      case (vecs[i].kind)
        1: chk("lit_rdata", last_rdata, vecs[i].lit);
        2: chk("lit_mem", mem[vecs[i].addr[7:2]], vecs[i].lit);
        3: chk("lit_err", last_err, vecs[i].lit);
        default: ;
      endcase
    end
    chk("poke_ignored", mem[32], 32'h0);

    // Byte store interrupted by reset during WRITE: memory must keep CAFEF00D.
    chk_on = 0;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h49; bus.req_wdata = 32'h00000077; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 chk("rstw_mem_we_before", 32'(bus.mem_we), 32'(1));
    #2 reset = 1'b0;
    #1;
    chk("rstw_mem_we_after", 32'(bus.mem_we), 32'(0));
    chk("rstw_req_ready", 32'(bus.req_ready), 32'(1));
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    repeat (2) @(posedge clk);
    #1 chk("rstw_mem_word", mem[18], 32'hCAFEF00D);
    $display("reset during WRITE: mem[0x48]=%h", mem[18]);
    @(negedge clk);
    reset  = 1'b1;
    chk_on = 1;

    do_req(0, 2'd2, 0, 32'h48, 32'h0, 0);
    $display("post-reset load 0x48 -> rdata=%h err=%0d", last_rdata, last_err);
    chk("post_rst_load", last_rdata, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
